// File: rtl/instruction_encoder_pkg.sv
// Shared types for the instruction encoder: field formats, run-control states,
// RISC-V base opcodes and the field-bundle payload.
package encoder_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // One field bundle as presented on the input handshake.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [19:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// instr_pack: combinational packer from a field bundle to a 32-bit RISC-V word.
// Ports: fields (bundle in), instr (packed word out),
//        illegal (only with ENC_CHECK_EN: fmt>5 or opcode[1:0]!=2'b11).
// Formats 6/7 pack as R-type.
module instr_pack
  import encoder_pkg::*;
(
  input  instr_fields_t        fields,
  output logic [INSTR_W-1:0]   instr
`ifdef ENC_CHECK_EN
  ,
  output logic                 illegal
`endif
);

  // Immediate scatter follows the RISC-V base encodings; B/J immediates are
  // already offset>>1.
  always_comb begin
    instr = '0;
    case (fields.fmt)
      FMT_I: instr = {fields.imm[11:0], fields.rs1, fields.func3, fields.rd, fields.opcode};
      FMT_S: instr = {fields.imm[11:5], fields.rs2, fields.rs1, fields.func3,
                      fields.imm[4:0], fields.opcode};
      FMT_B: instr = {fields.imm[11], fields.imm[9:4], fields.rs2, fields.rs1, fields.func3,
                      fields.imm[3:0], fields.imm[10], fields.opcode};
      FMT_U: instr = {fields.imm[19:0], fields.rd, fields.opcode};
      FMT_J: instr = {fields.imm[19], fields.imm[9:0], fields.imm[10], fields.imm[18:11],
                      fields.rd, fields.opcode};
      default: instr = {fields.func7, fields.rs2, fields.rs1, fields.func3, fields.rd,
                        fields.opcode};
    endcase
  end

`ifdef ENC_CHECK_EN
  always_comb begin
    illegal = (fields.fmt > 3'(FMT_J)) || (fields.opcode[1:0] != 2'b11);
  end
`endif

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs field bundles into instructions and streams them
// into instruction memory through one registered output stage.
// Ports: clk, rst_n; start (session pulse); in_valid/in_ready/in_last + fields
//        (fmt, opcode, destination_reg, func3, source1_reg, source2_reg, func7,
//        immediate_data); mem_we/mem_addr/mem_wdata/mem_ready (memory side);
//        busy, done, overflow, word_count (status).
// Optional macro ENC_CHECK_EN adds illegal/err_count and drops illegal bundles.
module instruction_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        destination_reg,
  input  logic [2:0]        func3,
  input  logic [4:0]        source1_reg,
  input  logic [4:0]        source2_reg,
  input  logic [6:0]        func7,
  input  logic [19:0]       immediate_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
`ifdef ENC_CHECK_EN
  ,
  output logic              illegal,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] BASE_C  = CNT_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0] END_C   = CNT_W'(BASE_ADDR + DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;     // words committed + pending
  logic [CNT_W-1:0]     word_count_q, word_count_d;
  logic                 full_q, full_d;           // drain entered on DEPTH, not in_last
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 in_ready_c, accept_c, write_c, fire_c;
  instr_fields_t        fields_c;
  logic [INSTR_W-1:0]   word_c;
`ifdef ENC_CHECK_EN
  logic                 illegal_c;
  logic                 illegal_q, illegal_d;
  logic [7:0]           err_count_q, err_count_d;
`endif

  always_comb begin
    fields_c.fmt    = fmt;
    fields_c.opcode = opcode;
    fields_c.rd     = destination_reg;
    fields_c.func3  = func3;
    fields_c.rs1    = source1_reg;
    fields_c.rs2    = source2_reg;
    fields_c.func7  = func7;
    fields_c.imm    = immediate_data;
  end

  instr_pack u_pack (
    .fields  (fields_c),
    .instr   (word_c)
`ifdef ENC_CHECK_EN
    ,
    .illegal (illegal_c)
`endif
  );

  // Input handshake and output-stage commit.
  always_comb begin
    in_ready_c = (state_q == RUN) && (!out_valid_q || mem_ready) && (acc_cnt_q < DEPTH_C);
    accept_c   = in_valid && in_ready_c;
    fire_c     = out_valid_q && mem_ready;
`ifdef ENC_CHECK_EN
    write_c    = accept_c && !illegal_c;
`else
    write_c    = accept_c;
`endif
  end

  // Run-control next state and datapath updates.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    mem_addr_d   = mem_addr_q;
    addr_d       = addr_q;
    acc_cnt_d    = acc_cnt_q;
    word_count_d = word_count_q;
    full_d       = full_q;
    overflow_d   = overflow_q;
`ifdef ENC_CHECK_EN
    illegal_d    = illegal_q;
    err_count_d  = err_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          addr_d       = BASE_C;
          acc_cnt_d    = '0;
          word_count_d = '0;
          full_d       = 1'b0;
          overflow_d   = 1'b0;
`ifdef ENC_CHECK_EN
          illegal_d    = 1'b0;
          err_count_d  = '0;
`endif
        end
      end
      RUN: begin
        if (accept_c) begin
          if (in_last) begin
            state_d = DRAIN;
          end else if (write_c && (acc_cnt_q + ONE_C == DEPTH_C)) begin
            state_d = DRAIN;
            full_d  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (full_q && in_valid) overflow_d = 1'b1;
        if (!out_valid_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fire_c) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + ONE_C;
      if (addr_q < END_C) addr_d = addr_q + ONE_C;
    end

    // A new word loads while the previous one commits, so it takes the next address.
    if (write_c) begin
      out_valid_d = 1'b1;
      out_data_d  = word_c;
      mem_addr_d  = ADDR_W'(fire_c ? addr_q + ONE_C : addr_q);
      acc_cnt_d   = acc_cnt_q + ONE_C;
    end

`ifdef ENC_CHECK_EN
    if (accept_c && illegal_c) begin
      illegal_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
`endif

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      mem_addr_q   <= '0;
      addr_q       <= BASE_C;
      acc_cnt_q    <= '0;
      word_count_q <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ENC_CHECK_EN
      illegal_q    <= 1'b0;
      err_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      mem_addr_q   <= mem_addr_d;
      addr_q       <= addr_d;
      acc_cnt_q    <= acc_cnt_d;
      word_count_q <= word_count_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef ENC_CHECK_EN
      illegal_q    <= illegal_d;
      err_count_q  <= err_count_d;
`endif
    end
  end

  assign in_ready   = in_ready_c;
  assign mem_we     = out_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = out_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;
`ifdef ENC_CHECK_EN
  assign illegal    = illegal_q;
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder (DEPTH=4 so the depth limit is reachable).
module tb_instruction_encoder;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CW        = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, in_ready, in_last;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        destination_reg, source1_reg, source2_reg;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [19:0]       immediate_data;
  logic              mem_we, mem_ready, busy, done, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
`ifdef ENC_CHECK_EN
  logic              illegal;
  logic [7:0]        err_count;
`endif

  always #5 clk = ~clk;

  instruction_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .destination_reg(destination_reg), .func3(func3),
    .source1_reg(source1_reg), .source2_reg(source2_reg), .func7(func7),
    .immediate_data(immediate_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
`ifdef ENC_CHECK_EN
    , .illegal(illegal), .err_count(err_count)
`endif
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t              sb[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                done_cnt = 0;
  int                done_base = 0;
  int                last_wait = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  // Reference encoder built from the architectural branch/jump offsets.
  function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op,
                                      input logic [4:0] rd, input logic [2:0] f3,
                                      input logic [4:0] r1, input logic [4:0] r2,
                                      input logic [6:0] f7, input logic [19:0] imm);
    logic [12:0] boff;
    logic [20:0] joff;
    boff = {imm[11:0], 1'b0};
    joff = {imm, 1'b0};
    case (f)
      3'd1:    enc = {imm[11:0], r1, f3, rd, op};
      3'd2:    enc = {imm[11:5], r2, r1, f3, imm[4:0], op};
      3'd3:    enc = {boff[12], boff[10:5], r2, r1, f3, boff[4:1], boff[11], op};
      3'd4:    enc = {imm, rd, op};
      3'd5:    enc = {joff[20], joff[10:1], joff[11], joff[19:12], rd, op};
      default: enc = {f7, r2, r1, f3, rd, op};
    endcase
  endfunction

  // Scoreboard side: every committed write pops and checks one expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (done === 1'b1) done_cnt++;
      if (rst_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: got addr=%0h data=%08h, required no write",
                   mem_addr, mem_wdata);
        end else begin
          e = sb.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            n_err++;
            $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [6:0] f7, input logic [19:0] imm, input logic last);
    fmt = f; opcode = op; destination_reg = rd; func3 = f3;
    source1_reg = r1; source2_reg = r2; func7 = f7; immediate_data = imm; in_last = last;
  endtask

  // Offers one bundle from a negedge; returns on the negedge after acceptance.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [6:0] f7, input logic [19:0] imm, input logic last,
                      input logic [31:0] exp_word, input bit writes);
    bit ok;
    ok = 1'b0;
    set_fields(f, op, rd, f3, r1, r2, f7, imm, last);
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (in_ready === 1'b1) begin
        if (writes) begin
          sb.push_back('{addr: exp_addr, data: exp_word});
          exp_addr++;
        end
        last_wait = c;
        ok = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: got in_ready=%b for 40 cycles, required 1", in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic start_session();
    for (int c = 0; c < 20 && busy !== 1'b0; c++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr  = ADDR_W'(BASE_ADDR);
    done_base = done_cnt;
    #1;
    n_vec++;
    if (busy !== 1'b1 || word_count !== '0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL start: got busy=%b word_count=%0d overflow=%b, required 1 0 0",
               busy, word_count, overflow);
    end
    @(negedge clk);
  endtask

  task automatic finish_session(input int exp_wc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done_cnt != done_base) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #3;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: got no done pulse in 50 cycles, required one");
    end
    @(negedge clk);
    #3;
    n_vec++;
    if (done_cnt !== done_base + 1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got pulses=%0d busy=%b done=%b, required 1 0 0",
               done_cnt - done_base, busy, done);
    end
    n_vec++;
    if (word_count !== CW'(exp_wc)) begin
      n_err++;
      $display("FAIL word_count: got %0d, required %0d", word_count, exp_wc);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL pending_writes: got %0d unwritten, required 0", sb.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_vec++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || overflow !== 1'b0 || word_count !== '0 || in_ready !== 1'b0
`ifdef ENC_CHECK_EN
        || illegal !== 1'b0 || err_count !== '0
`endif
        ) begin
      n_err++;
      $display("FAIL %s: got we=%b addr=%0h wdata=%08h busy=%b done=%b ovf=%b wc=%0d rdy=%b, required all 0",
               name, mem_we, mem_addr, mem_wdata, busy, done, overflow, word_count, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    set_fields(3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 20'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_r();
    start_session();
    send(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 20'd0, 1'b1, 32'h002081B3, 1'b1);
    finish_session(1);
  endtask

  task automatic test_back_to_back();
    int waits;
    start_session();
    send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'd5, 1'b0, 32'h00500093, 1'b1);
    send(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 20'd8, 1'b0, 32'h0020A423, 1'b1);
    waits = last_wait;
    send(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 20'h12345, 1'b1, 32'h123452B7, 1'b1);
    waits += last_wait;
    n_vec++;
    if (waits != 0) begin
      n_err++;
      $display("FAIL back_to_back: got %0d stall cycles, required 0", waits);
    end
    finish_session(3);
  endtask

  task automatic test_branch_jump();
    start_session();
    send(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 20'd8, 1'b0, 32'h00208863, 1'b1);
    send(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'd4, 1'b1, 32'h008000EF, 1'b1);
    finish_session(2);
  endtask

  task automatic test_backpressure();
    logic [31:0] w1, w2;
    w1 = enc(3'd1, 7'h13, 5'd7, 3'd1, 5'd4, 5'd0, 7'd0, 20'h00ABC);
    w2 = enc(3'd0, 7'h33, 5'd9, 3'd5, 5'd10, 5'd11, 7'h20, 20'd0);
    start_session();
    send(3'd4, 7'h37, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 20'hFEDCB, 1'b0,
         enc(3'd4, 7'h37, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 20'hFEDCB), 1'b1);
    send(3'd1, 7'h13, 5'd7, 3'd1, 5'd4, 5'd0, 7'd0, 20'h00ABC, 1'b0, w1, 1'b1);
    mem_ready = 1'b0;
    set_fields(3'd0, 7'h33, 5'd9, 3'd5, 5'd10, 5'd11, 7'h20, 20'd0, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(1) || mem_wdata !== w1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold: got we=%b addr=%0h wdata=%08h rdy=%b, required 1 1 %08h 0",
                 mem_we, mem_addr, mem_wdata, in_ready, w1);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    send(3'd0, 7'h33, 5'd9, 3'd5, 5'd10, 5'd11, 7'h20, 20'd0, 1'b0, w2, 1'b1);
    send(3'd5, 7'h6F, 5'd31, 3'd0, 5'd0, 5'd0, 7'd0, 20'hF0F0F, 1'b1,
         enc(3'd5, 7'h6F, 5'd31, 3'd0, 5'd0, 5'd0, 7'd0, 20'hF0F0F), 1'b1);
    finish_session(4);
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_on_last: got %b, required 0", overflow);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] imm;
    start_session();
    for (int i = 0; i < 4; i++) begin
      imm = 20'($urandom);
      send(3'd1, 7'h13, 5'(i + 1), 3'd0, 5'd2, 5'd0, 7'd0, imm, 1'b0,
           enc(3'd1, 7'h13, 5'(i + 1), 3'd0, 5'd2, 5'd0, 7'd0, imm), 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      set_fields(3'd4, 7'h37, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 20'(i), 1'b0);
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL ready_when_full: got in_ready=%b, required 0", in_ready);
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    finish_session(4);
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: got %b, required 1", overflow);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [6:0]  op, f7;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [19:0] imm;
    for (int s = 0; s < 3; s++) begin
      start_session();
      for (int i = 0; i < 4; i++) begin
`ifdef ENC_CHECK_EN
        f = 3'($urandom_range(0, 5));
`else
        f = 3'($urandom_range(0, 7));
`endif
        op = {5'($urandom), 2'b11};
        rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
        f3 = 3'($urandom); f7 = 7'($urandom); imm = 20'($urandom);
        send(f, op, rd, f3, r1, r2, f7, imm, (i == 3), enc(f, op, rd, f3, r1, r2, f7, imm), 1'b1);
      end
      finish_session(4);
    end
  endtask

  task automatic test_reset_mid();
    start_session();
    send(3'd1, 7'h13, 5'd4, 3'd0, 5'd4, 5'd0, 7'd0, 20'd1, 1'b0,
         enc(3'd1, 7'h13, 5'd4, 3'd0, 5'd4, 5'd0, 7'd0, 20'd1), 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    send(3'd4, 7'h37, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 20'hABCDE, 1'b0,
         enc(3'd4, 7'h37, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 20'hABCDE), 1'b1);
    #1;
    n_vec++;
    if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(1)) begin
      n_err++;
      $display("FAIL stalled_before_reset: got we=%b addr=%0h, required 1 1", mem_we, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_midsession");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    start_session();
    send(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 20'd0, 1'b1, 32'h002081B3, 1'b1);
    finish_session(1);
  endtask

`ifdef ENC_CHECK_EN
  task automatic test_check();
    start_session();
    send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'd5, 1'b0, 32'h00500093, 1'b1);
    send(3'd7, 7'h33, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 20'd0, 1'b0, 32'h0, 1'b0);
    send(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 20'h12345, 1'b1, 32'h123452B7, 1'b1);
    finish_session(2);
    n_vec++;
    if (illegal !== 1'b1 || err_count !== 8'd1) begin
      n_err++;
      $display("FAIL illegal_flag: got illegal=%b err_count=%0d, required 1 1", illegal, err_count);
    end
    start_session();
    n_vec++;
    if (illegal !== 1'b0 || err_count !== 8'd0) begin
      n_err++;
      $display("FAIL illegal_clear: got illegal=%b err_count=%0d, required 0 0", illegal, err_count);
    end
    send(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 20'd0, 1'b1, 32'h002081B3, 1'b1);
    finish_session(1);
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_r();
    test_back_to_back();
    test_branch_jump();
    test_backpressure();
    test_overflow();
    test_random();
    test_reset_mid();
`ifdef ENC_CHECK_EN
    test_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Packs RISC-V instruction fields into 32-bit instruction words and streams them into instruction memory. It is the write-side counterpart of instruction_decoder and uses the same field names and widths. Typical users are the testbench program loader and the self-test sequencer. It has a valid/ready field input, a single registered output stage with memory backpressure, an address counter and a run-control FSM.

Parameters:
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start
DEPTH, 256, number of writable words; must be <= 2**ADDR_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load session
in_valid  in  1  field bundle valid
in_ready  out  1  field bundle accepted when in_valid && in_ready
in_last  in  1  marks the final bundle of the session
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J
opcode  in  7  instruction[6:0]
destination_reg  in  5  rd
func3  in  3  func3
source1_reg  in  5  rs1
source2_reg  in  5  rs2
func7  in  7  func7 (R only)
immediate_data  in  20  immediate; per-format packing below
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded instruction
mem_ready  in  1  memory accepts the write when mem_we && mem_ready
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse at end of session
overflow  out  1  sticky; DEPTH words written and more data offered
word_count  out  ADDR_W+1  words committed this session

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs are 0. Internal address = BASE_ADDR and output-stage valid = 0. This applies mid-session as well; a pending write is dropped.
- FSM states:
  - IDLE: in_ready=0. start moves to RUN and clears word_count, overflow and the address to BASE_ADDR.
  - RUN: accepts bundles. Acceptance with in_last moves to DRAIN.
  - If word_count+pending reaches DEPTH while not last, move to DRAIN and set overflow when in_valid is seen again in DRAIN.
  - DRAIN: waits until the output stage is empty, then moves to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start is ignored outside IDLE.
- in_ready = (state==RUN) && (!out_valid || mem_ready) && (accepted words < DEPTH).
- Latency: a bundle accepted at edge N gives mem_we=1 with its word after edge N. Back-to-back throughput is 1 word/cycle when mem_ready=1.
- The output stage holds mem_wdata and mem_addr stable while mem_we && !mem_ready.
- On mem_we && mem_ready: address+1 and word_count+1. The address does not wrap; it stops at BASE_ADDR+DEPTH.
- Packing (instruction bits; immd = immediate_data). [6:0]=opcode in every format.
  - R: [31:25]=func7, [24:20]=rs2, [19:15]=rs1, [14:12]=func3, [11:7]=rd.
  - I: [31:20]=immd[11:0], rs1, func3, rd.
  - S: [31:25]=immd[11:5], rs2, rs1, func3, [11:7]=immd[4:0].
  - B (immd[11:0]=offset[12:1]): [31]=immd[11], [30:25]=immd[9:4], rs2, rs1, func3, [11:8]=immd[3:0], [7]=immd[10].
  - U: [31:12]=immd[19:0], rd.
  - J (immd=offset[20:1]): [31]=immd[19], [30:21]=immd[9:0], [20]=immd[10], [19:12]=immd[18:11], [11:7]=rd.
  - Unused immd bits are ignored.
  - fmt 6/7 packs as R when the optional feature is absent.

Optional Feature:
ENC_CHECK_EN
- Defined:
  - A bundle with fmt>5 or opcode[1:0]!=2'b11 is accepted but not written.
  - Output illegal (1 bit, sticky per session) is set, and err_count (8 bits, saturating) increments.
  - Both are cleared by start and by reset.
- Undefined: those ports and the checker are absent, and every bundle is written.

Decomposition:
- Package encoder_pkg holds:
  - the fmt_e enum (FMT_R..FMT_J)
  - the state_e enum (IDLE, RUN, DRAIN, DONE)
  - the RISC-V opcode localparams
- Sub-module instr_pack: purely combinational. Takes fmt plus the fields and returns the 32-bit word, plus the illegal flag under ENC_CHECK_EN. It is reusable by the bench scoreboard.

Test Plan:
- start; R fmt, opcode 0x33, rd=3, rs1=1, rs2=2, func3=0, func7=0, in_last=1 -> one write of 0x002081B3 @ addr 0, then done pulse, word_count=1.
- I ADDI rd=1, imm=5 (0x13); S SW rs1=1, rs2=2, func3=2, imm=8 (0x23); U LUI rd=5, immd=0x12345 (0x37), back-to-back -> 0x00500093, 0x0020A423, 0x123452B7 @ addrs 0, 1, 2 in consecutive cycles.
- B BEQ rs1=1, rs2=2, immd=8 (0x63); J JAL rd=1, immd=4 (0x6F) -> 0x00208863, 0x008000EF.
- mem_ready=0 for 3 cycles mid-stream -> mem_we, mem_addr and mem_wdata held, in_ready=0, no bundle lost or duplicated.
- DEPTH=4, 6 bundles offered without in_last -> 4 writes, overflow=1, done pulse, busy=0.
- rst_n asserted while mem_we=1 stalled -> all outputs 0 immediately; a new start writes again from BASE_ADDR.
- ENC_CHECK_EN: fmt=7 bundle between two legal ones -> only 2 writes, illegal=1, err_count=1.
